// File: rtl/kitchen_display_scan_pkg.sv
// Shared display definitions: 7-segment patterns {g,f,e,d,c,b,a}, scan slot codes and the BCD frame type.
// The down counter and the top level use the same constants.
package kitchen_display_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] SLOT_MH = 2'd0;
    localparam logic [1:0] SLOT_ML = 2'd1;
    localparam logic [1:0] SLOT_SH = 2'd2;
    localparam logic [1:0] SLOT_SL = 2'd3;

    typedef struct packed {
        logic [3:0] m_hi;
        logic [3:0] m_lo;
        logic [3:0] s_hi;
        logic [3:0] s_lo;
    } bcd_frame_t;

endpackage

// File: rtl/kitchen_display_scan_seg7_decode.sv
// BCD to 7-segment pattern decoder. Codes 10..15 produce a blank pattern.
module seg7_decode
    import kitchen_display_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/kitchen_display_scan.sv
// Four-digit MM:SS multiplexed 7-segment scanner with anti-ghost guard, leading-zero blanking and blink.
// Slot FSM:
//   state   | meaning
//   SLOT_MH | DIG_1 window, minutes tens (frame snapshot taken on entry)
//   SLOT_ML | DIG_2 window, minutes units
//   SLOT_SH | DIG_3 window, seconds tens
//   SLOT_SL | DIG_4 window, seconds units
module kitchen_display_scan
    import kitchen_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 244,
    parameter int GUARD     = 8,
    parameter int BLINK_DIV = 122070
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic [3:0] M_HI,
    input  logic [3:0] M_LO,
    input  logic [3:0] S_HI,
    input  logic [3:0] S_LO,
    input  logic       BLINK_EN,
    input  logic       LZ_BLANK,
    output logic       DIG_1,
    output logic       DIG_2,
    output logic       DIG_3,
    output logic       DIG_4,
    output logic [6:0] LIGHT_SEG
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);

    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_nxt;
    logic             tick;
    logic             guard_end;

    logic [1:0]       slot;
    logic [1:0]       slot_nxt;
    logic             running;
    logic             load_frame;

    bcd_frame_t       live;
    bcd_frame_t       snap;
    bcd_frame_t       view;
    logic [3:0]       digit_nxt;
    logic [6:0]       seg_dec;
    logic             suppress;
    logic             suppress_nxt;

    logic [3:0]       dig_scan;
    logic [3:0]       dig_scan_nxt;
    logic [3:0]       dig_q;

    logic [BLK_W-1:0] blink_cnt;
    logic [BLK_W-1:0] blink_cnt_nxt;
    logic             blink_on;
    logic             blink_on_nxt;

    assign live = {M_HI, M_LO, S_HI, S_LO};

    seg7_decode u_seg7_decode (
        .bcd (digit_nxt),
        .seg (seg_dec)
    );

    always_comb begin
        tick       = (presc == PRE_W'(SCAN_DIV - 1));
        guard_end  = (presc == PRE_W'(GUARD - 1));
        presc_nxt  = tick ? '0 : presc + 1'b1;

        // Before the first tick nothing is loaded, so the first tick enters SLOT_MH rather than advancing.
        slot_nxt   = running ? slot + 2'd1 : SLOT_MH;
        load_frame = tick && (slot_nxt == SLOT_MH);

        // The frame-start slot reads the live inputs; the rest of the frame reads the snapshot.
        view = load_frame ? live : snap;

        digit_nxt = view.m_hi;
        case (slot_nxt)
            SLOT_MH: digit_nxt = view.m_hi;
            SLOT_ML: digit_nxt = view.m_lo;
            SLOT_SH: digit_nxt = view.s_hi;
            SLOT_SL: digit_nxt = view.s_lo;
            default: digit_nxt = view.m_hi;
        endcase

        suppress_nxt = (slot_nxt == SLOT_MH) && LZ_BLANK && (view.m_hi == 4'd0);

        dig_scan_nxt = dig_scan;
        if (tick) begin
            dig_scan_nxt = '0;
        end else if (guard_end && running && !suppress) begin
            dig_scan_nxt = 4'b0001 << slot;
        end

        blink_cnt_nxt = blink_cnt;
        blink_on_nxt  = blink_on;
        if (!BLINK_EN) begin
            blink_cnt_nxt = '0;
            blink_on_nxt  = 1'b1;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_nxt = '0;
            blink_on_nxt  = !blink_on;
        end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            presc     <= '0;
            slot      <= SLOT_MH;
            running   <= 1'b0;
            snap      <= '0;
            suppress  <= 1'b0;
            dig_scan  <= '0;
            dig_q     <= '0;
            LIGHT_SEG <= SEG_BLANK;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            presc     <= presc_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_on  <= blink_on_nxt;
            dig_scan  <= dig_scan_nxt;
            // Blink gates only the enables; the scan itself keeps running underneath.
            dig_q     <= dig_scan_nxt & {4{blink_on_nxt}};
            if (tick) begin
                slot      <= slot_nxt;
                running   <= 1'b1;
                suppress  <= suppress_nxt;
                LIGHT_SEG <= suppress_nxt ? SEG_BLANK : seg_dec;
            end
            if (load_frame) begin
                snap <= live;
            end
        end
    end

    assign DIG_1 = dig_q[0];
    assign DIG_2 = dig_q[1];
    assign DIG_3 = dig_q[2];
    assign DIG_4 = dig_q[3];

endmodule
